// File: rtl/key_extract_reli_tx_pkg.sv
// Shared definitions for the reliable-TX lookup path: property bit positions,
// default field offsets and the key type encodings used by the table and the action block.
package key_extract_reli_tx_pkg;

   localparam int PROP_DAT_BIT   = 0;
   localparam int PROP_NACK_BIT  = 1;
   localparam int PROP_LOCAL_BIT = 2;
   localparam int PROP_WIDTH     = 3;

   localparam int DEF_DST_IP_NO         = 104;
   localparam int DEF_SRC_IP_NO         = 0;
   localparam int DEF_IP_WIDTH          = 128;
   localparam int DEF_RSIP_INDEX_NO     = 241;
   localparam int DEF_RSIP_INDEX_WIDTH  = 5;
   localparam int DEF_PKT_PROPERTY_NO   = 246;

   typedef enum logic [1:0] {
      KEY_TYPE_MISS = 2'd0,
      KEY_TYPE_DAT  = 2'd1,
      KEY_TYPE_NACK = 2'd2
   } key_type_e;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_FULL  = 2'd2
   } skid_state_e;

   // DAT has priority over NACK; both require the LOCAL bit
   function automatic key_type_e classify(input logic [PROP_WIDTH-1:0] prop);
      if (prop[PROP_DAT_BIT] && prop[PROP_LOCAL_BIT]) begin
         return KEY_TYPE_DAT;
      end else if (prop[PROP_NACK_BIT] && prop[PROP_LOCAL_BIT]) begin
         return KEY_TYPE_NACK;
      end
      return KEY_TYPE_MISS;
   endfunction

endpackage

// File: rtl/key_extract_reli_tx_skid_buf.sv
// Two-entry valid/ready register slice; in_ready depends only on the registered
// state, so there is no combinational path from out_ready back to the producer.
module reli_tx_skid_buf
   import key_extract_reli_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   skid_state_e           state, state_next;
   logic [DATA_WIDTH-1:0] out_q, skid_q;
   logic                  push, pop;
   logic                  load_out_in, load_out_skid, load_skid;

   assign in_ready  = (state != SKID_FULL) && !rst;
   assign out_valid = (state != SKID_EMPTY);
   assign out_data  = out_q;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      state_next    = state;
      load_out_in   = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      case (state)
         SKID_EMPTY: begin
            if (push) begin
               state_next  = SKID_ONE;
               load_out_in = 1'b1;
            end
         end
         SKID_ONE: begin
            if (push && pop) begin
               load_out_in = 1'b1;
            end else if (push) begin
               state_next = SKID_FULL;
               load_skid  = 1'b1;
            end else if (pop) begin
               state_next = SKID_EMPTY;
            end
         end
         SKID_FULL: begin
            if (pop) begin
               state_next    = SKID_ONE;
               load_out_skid = 1'b1;
            end
         end
         default: state_next = SKID_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SKID_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Output data holds its last value after a pop; only out_valid matters then
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (load_out_in) begin
            out_q <= in_data;
         end else if (load_out_skid) begin
            out_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/key_extract_reli_tx.sv
// Lookup-key extractor for the reliable-TX match-action stage: classifies each
// metadata beat, builds the typed key and queues {type, key, metadata} through a skid buffer.
module key_extract_reli_tx
   import key_extract_reli_tx_pkg::*;
#(
   parameter int PKT_METADATA_WIDTH = 274,
   parameter int KEY_WIDTH          = 133,
   parameter int DST_IP_NO          = DEF_DST_IP_NO,
   parameter int SRC_IP_NO          = DEF_SRC_IP_NO,
   parameter int IP_WIDTH           = DEF_IP_WIDTH,
   parameter int RSIP_INDEX_NO      = DEF_RSIP_INDEX_NO,
   parameter int RSIP_INDEX_WIDTH   = DEF_RSIP_INDEX_WIDTH,
   parameter int PKT_PROPERTY_NO    = DEF_PKT_PROPERTY_NO,
   parameter int NACK_USE_SRC       = 1,
   parameter int FORWARD_MISS       = 1,
   parameter int CNT_WIDTH          = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PKT_METADATA_WIDTH-1:0] s_pkt_metadata_info,
   input  logic                          s_pkt_metadata_valid,
   output logic                          s_pkt_metadata_ready,
   output logic [KEY_WIDTH-1:0]          m_key_info,
   output logic [1:0]                    m_key_type,
   output logic [PKT_METADATA_WIDTH-1:0] m_key_metadata,
   output logic                          m_key_valid,
   input  logic                          m_key_ready,
   input  logic                          stat_clr,
   output logic [CNT_WIDTH-1:0]          stat_dat_cnt,
   output logic [CNT_WIDTH-1:0]          stat_nack_cnt,
   output logic [CNT_WIDTH-1:0]          stat_miss_cnt
);

   localparam int PAYLOAD_WIDTH = 2 + KEY_WIDTH + PKT_METADATA_WIDTH;

   logic [PROP_WIDTH-1:0]       prop;
   logic [RSIP_INDEX_WIDTH-1:0] rsip_index;
   logic [IP_WIDTH-1:0]         dst_ip, src_ip;
   key_type_e                   beat_type;
   logic [KEY_WIDTH-1:0]        beat_key;
   logic                        emit, accept;
   logic [PAYLOAD_WIDTH-1:0]    in_payload, out_payload;

   assign prop       = s_pkt_metadata_info[PKT_PROPERTY_NO +: PROP_WIDTH];
   assign rsip_index = s_pkt_metadata_info[RSIP_INDEX_NO +: RSIP_INDEX_WIDTH];
   assign dst_ip     = s_pkt_metadata_info[DST_IP_NO +: IP_WIDTH];
   assign src_ip     = s_pkt_metadata_info[SRC_IP_NO +: IP_WIDTH];

   always_comb begin
      beat_type = classify(prop);
      beat_key  = '0;
      case (beat_type)
         KEY_TYPE_DAT: begin
            beat_key[IP_WIDTH-1:0]                   = dst_ip;
            beat_key[IP_WIDTH +: RSIP_INDEX_WIDTH]   = rsip_index;
         end
         KEY_TYPE_NACK: begin
            beat_key[IP_WIDTH-1:0]                   = (NACK_USE_SRC != 0) ? src_ip : dst_ip;
            beat_key[IP_WIDTH +: RSIP_INDEX_WIDTH]   = rsip_index;
         end
         default: beat_key = '0;
      endcase
   end

   // Dropped miss beats are still consumed (and counted), just never queued
   assign emit       = (beat_type != KEY_TYPE_MISS) || (FORWARD_MISS != 0);
   assign accept     = s_pkt_metadata_valid && s_pkt_metadata_ready;
   assign in_payload = {beat_type, beat_key, s_pkt_metadata_info};

   reli_tx_skid_buf #(
      .DATA_WIDTH (PAYLOAD_WIDTH)
   ) u_skid_buf (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_payload),
      .in_valid  (s_pkt_metadata_valid && emit),
      .in_ready  (s_pkt_metadata_ready),
      .out_data  (out_payload),
      .out_valid (m_key_valid),
      .out_ready (m_key_ready)
   );

   assign m_key_type     = out_payload[PAYLOAD_WIDTH-1 -: 2];
   assign m_key_info     = out_payload[PKT_METADATA_WIDTH +: KEY_WIDTH];
   assign m_key_metadata = out_payload[PKT_METADATA_WIDTH-1:0];

   // A clear wins over a coincident increment; the coinciding beat is not counted
   always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
         stat_dat_cnt  <= '0;
         stat_nack_cnt <= '0;
         stat_miss_cnt <= '0;
      end else if (accept) begin
         case (beat_type)
            KEY_TYPE_DAT:  stat_dat_cnt  <= stat_dat_cnt + CNT_WIDTH'(1);
            KEY_TYPE_NACK: stat_nack_cnt <= stat_nack_cnt + CNT_WIDTH'(1);
            default:       stat_miss_cnt <= stat_miss_cnt + CNT_WIDTH'(1);
         endcase
      end
   end

endmodule

// File: tb/tb_key_extract_reli_tx.sv
// Self-checking bench for key_extract_reli_tx: vector table, backpressure, counter
// clear/wrap, reset flush and a randomized scoreboard run on default and alternate configs.
module tb_key_extract_reli_tx;

   localparam int MW = 274;
   localparam int KW = 133;
   localparam int CW = 32;
   localparam int P_PROP = 246;
   localparam int P_RSIP = 241;
   localparam int P_DST  = 104;
   localparam int P_SRC  = 0;

   typedef struct {
      logic [1:0]    typ;
      logic [KW-1:0] key;
      logic [MW-1:0] meta;
   } exp_t;

   typedef struct {
      logic [MW-1:0] meta;
      logic [1:0]    typ;
      logic [KW-1:0] key;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [MW-1:0] s_info;
   logic          s_valid;
   logic          s_ready;
   logic [KW-1:0] m_info;
   logic [1:0]    m_type;
   logic [MW-1:0] m_meta;
   logic          m_valid;
   logic          m_ready;
   logic          stat_clr;
   logic [CW-1:0] dat_cnt, nack_cnt, miss_cnt;

   logic [MW-1:0] alt_info;
   logic          alt_valid;
   logic          alt_ready;
   logic [KW-1:0] alt_m_info;
   logic [1:0]    alt_m_type;
   logic [MW-1:0] alt_m_meta;
   logic          alt_m_valid;
   logic          alt_m_ready = 1'b1;
   logic [1:0]    alt_dat_cnt, alt_nack_cnt, alt_miss_cnt;

   logic man_ready = 1'b1;
   logic rand_mode = 1'b0;
   logic rand_ready = 1'b1;

   int   total = 0;
   int   bad = 0;
   int   ref_dat = 0, ref_nack = 0, ref_miss = 0;
   exp_t sb_q[$];
   vec_t vecs[7];

   always #5 clk = ~clk;

   assign m_ready = rand_mode ? rand_ready : man_ready;

   key_extract_reli_tx dut (
      .clk                  (clk),
      .rst                  (rst),
      .s_pkt_metadata_info  (s_info),
      .s_pkt_metadata_valid (s_valid),
      .s_pkt_metadata_ready (s_ready),
      .m_key_info           (m_info),
      .m_key_type           (m_type),
      .m_key_metadata       (m_meta),
      .m_key_valid          (m_valid),
      .m_key_ready          (m_ready),
      .stat_clr             (stat_clr),
      .stat_dat_cnt         (dat_cnt),
      .stat_nack_cnt        (nack_cnt),
      .stat_miss_cnt        (miss_cnt)
   );

   key_extract_reli_tx #(
      .NACK_USE_SRC (0),
      .FORWARD_MISS (0),
      .CNT_WIDTH    (2)
   ) dut_alt (
      .clk                  (clk),
      .rst                  (rst),
      .s_pkt_metadata_info  (alt_info),
      .s_pkt_metadata_valid (alt_valid),
      .s_pkt_metadata_ready (alt_ready),
      .m_key_info           (alt_m_info),
      .m_key_type           (alt_m_type),
      .m_key_metadata       (alt_m_meta),
      .m_key_valid          (alt_m_valid),
      .m_key_ready          (alt_m_ready),
      .stat_clr             (stat_clr),
      .stat_dat_cnt         (alt_dat_cnt),
      .stat_nack_cnt        (alt_nack_cnt),
      .stat_miss_cnt        (alt_miss_cnt)
   );

   function automatic logic [MW-1:0] with_prop(input logic [MW-1:0] m, input logic [2:0] v);
      m[P_PROP +: 3] = v;
      return m;
   endfunction

   function automatic logic [MW-1:0] with_rsip(input logic [MW-1:0] m, input logic [4:0] v);
      m[P_RSIP +: 5] = v;
      return m;
   endfunction

   function automatic logic [MW-1:0] with_dst(input logic [MW-1:0] m, input logic [127:0] v);
      m[P_DST +: 128] = v;
      return m;
   endfunction

   function automatic logic [MW-1:0] with_src(input logic [MW-1:0] m, input logic [127:0] v);
      m[P_SRC +: 128] = v;
      return m;
   endfunction

   // Reference behaviour of the default configuration (source-IP NACK keys, misses forwarded)
   function automatic exp_t model(input logic [MW-1:0] m);
      exp_t       e;
      logic [2:0] p;
      p      = m[P_PROP +: 3];
      e.meta = m;
      e.typ  = 2'd0;
      e.key  = '0;
      if (p[2]) begin
         if (p[0]) begin
            e.typ = 2'd1;
            e.key = {m[P_RSIP +: 5], m[P_DST +: 128]};
         end else if (p[1]) begin
            e.typ = 2'd2;
            e.key = {m[P_RSIP +: 5], m[P_SRC +: 128]};
         end
      end
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic countRef(input logic [1:0] typ);
      case (typ)
         2'd1:    ref_dat++;
         2'd2:    ref_nack++;
         default: ref_miss++;
      endcase
   endtask

   // Holds a beat until the DUT takes it; returns just after the accepting edge
   task automatic applyStimulus(input exp_t e);
      bit accepted = 0;
      int waited = 0;
      s_info  = e.meta;
      s_valid = 1'b1;
      while (!accepted && waited < 200) begin
         @(negedge clk);
         if (s_ready) begin
            accepted = 1;
            sb_q.push_back(e);
            countRef(e.typ);
         end
         waited++;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      if (!accepted) begin
         total++;
         bad++;
         $display("[TB] FAIL accept_timeout actual=%0d required=accept", waited);
      end
   endtask

   task automatic applyStimulusAlt(input logic [MW-1:0] m);
      bit accepted = 0;
      int waited = 0;
      alt_info  = m;
      alt_valid = 1'b1;
      while (!accepted && waited < 200) begin
         @(negedge clk);
         if (alt_ready) accepted = 1;
         waited++;
         @(posedge clk);
         #1;
      end
      alt_valid = 1'b0;
      if (!accepted) begin
         total++;
         bad++;
         $display("[TB] FAIL alt_accept_timeout actual=%0d required=accept", waited);
      end
   endtask

   task automatic waitDrain();
      int waited = 0;
      while (sb_q.size() != 0 && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("drain_empty", MW'(sb_q.size()), '0);
      @(posedge clk);
      #1;
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, "_dat_cnt"},  MW'(dat_cnt),  MW'(ref_dat));
      checkOutput({tag, "_nack_cnt"}, MW'(nack_cnt), MW'(ref_nack));
      checkOutput({tag, "_miss_cnt"}, MW'(miss_cnt), MW'(ref_miss));
   endtask

   // Random downstream readiness for the soak phase
   always @(posedge clk) begin
      #1;
      rand_ready = ($urandom_range(0, 3) != 0);
   end

   // Output monitor: an accepted output must match the oldest expected beat
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL sb_unexpected actual=type%0d key=%0h required=no_output", m_type, m_info);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            checkOutput("sb_type", MW'(m_type), MW'(e.typ));
            checkOutput("sb_key",  MW'(m_info), MW'(e.key));
            checkOutput("sb_meta", m_meta, e.meta);
         end
      end
   end

   initial begin
      #5ms;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [MW-1:0] m;
      exp_t          e;

      vecs[0].meta = with_prop(with_rsip(with_dst(with_src('0, 128'h0), 128'h1), 5'h0A), 3'b101);
      vecs[0].typ  = 2'd1;
      vecs[0].key  = {5'h0A, 128'h1};
      vecs[1].meta = with_prop(with_rsip(with_src(with_dst('0, 128'h0), 128'hAB), 5'h03), 3'b110);
      vecs[1].typ  = 2'd2;
      vecs[1].key  = {5'h03, 128'hAB};
      vecs[2].meta = with_prop(with_rsip(with_dst('0, 128'h55), 5'h07), 3'b011);
      vecs[2].typ  = 2'd0;
      vecs[2].key  = '0;
      vecs[3].meta = with_prop(with_rsip(with_dst('0, 128'h1234), 5'h1F), 3'b111);
      vecs[3].typ  = 2'd1;
      vecs[3].key  = {5'h1F, 128'h1234};
      vecs[4].meta = with_prop(with_rsip(with_dst('0, 128'h66), 5'h01), 3'b100);
      vecs[4].typ  = 2'd0;
      vecs[4].key  = '0;
      vecs[5].meta = with_prop(with_rsip(with_dst('0, 128'h9), 5'h02), 3'b001);
      vecs[5].typ  = 2'd0;
      vecs[5].key  = '0;
      vecs[6].meta = with_prop(with_rsip(with_src(with_dst('0, 128'h5), {128{1'b1}}), 5'h11), 3'b110);
      vecs[6].meta[273:249] = 25'h1ABCDEF;
      vecs[6].typ  = 2'd2;
      vecs[6].key  = {5'h11, {128{1'b1}}};

      rst       = 1'b1;
      s_valid   = 1'b0;
      s_info    = '0;
      alt_valid = 1'b0;
      alt_info  = '0;
      stat_clr  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_ready_low", MW'(s_ready), '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_ready_high", MW'(s_ready), MW'(1));
      checkOutput("rst_valid",      MW'(m_valid), '0);
      checkOutput("rst_info",       MW'(m_info),  '0);
      checkOutput("rst_type",       MW'(m_type),  '0);
      checkOutput("rst_meta",       m_meta,       '0);
      checkCounters("rst");
      @(posedge clk);
      #1;

      $display("[TB] vector table");
      for (int i = 0; i < 7; i++) begin
         e.meta = vecs[i].meta;
         e.typ  = vecs[i].typ;
         e.key  = vecs[i].key;
         applyStimulus(e);
         @(negedge clk);
         checkOutput($sformatf("lat_valid_%0d", i), MW'(m_valid), MW'(1));
         checkOutput($sformatf("lat_type_%0d", i),  MW'(m_type),  MW'(vecs[i].typ));
         if (i == 0) checkOutput("first_dat_cnt", MW'(dat_cnt), MW'(1));
         @(posedge clk);
         #1;
      end
      waitDrain();
      checkCounters("table");

      $display("[TB] alternate config");
      m = with_prop(with_rsip(with_dst(with_src('0, 128'hAB), 128'h77), 5'h04), 3'b110);
      applyStimulusAlt(m);
      @(negedge clk);
      checkOutput("alt_nack_valid", MW'(alt_m_valid), MW'(1));
      checkOutput("alt_nack_type",  MW'(alt_m_type),  MW'(2));
      checkOutput("alt_nack_key",   MW'(alt_m_info),  MW'({5'h04, 128'h77}));
      @(posedge clk);
      #1;
      applyStimulusAlt(with_prop(m, 3'b011));
      @(negedge clk);
      checkOutput("alt_miss_dropped", MW'(alt_m_valid),  '0);
      checkOutput("alt_miss_cnt1",    MW'(alt_miss_cnt), MW'(1));
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) applyStimulusAlt(with_prop(m, 3'b010));
      @(negedge clk);
      checkOutput("alt_miss_wrap", MW'(alt_miss_cnt), MW'(1));
      checkOutput("alt_nack_cnt",  MW'(alt_nack_cnt), MW'(1));
      checkOutput("alt_no_output", MW'(alt_m_valid),  '0);
      @(posedge clk);
      #1;

      $display("[TB] backpressure");
      man_ready = 1'b0;
      applyStimulus(model(vecs[0].meta));
      applyStimulus(model(vecs[1].meta));
      s_info  = vecs[3].meta;
      s_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput($sformatf("bp_ready_low_%0d", i), MW'(s_ready), '0);
         checkOutput($sformatf("bp_hold_key_%0d", i),  MW'(m_info),  MW'(vecs[0].key));
         checkOutput($sformatf("bp_hold_valid_%0d", i), MW'(m_valid), MW'(1));
      end
      @(posedge clk);
      #1;
      man_ready = 1'b1;
      applyStimulus(model(vecs[3].meta));
      waitDrain();
      checkCounters("bp");

      $display("[TB] stat_clr with accept");
      stat_clr = 1'b1;
      applyStimulus(model(vecs[0].meta));
      stat_clr = 1'b0;
      ref_dat  = 0;
      ref_nack = 0;
      ref_miss = 0;
      @(negedge clk);
      checkCounters("clr");
      waitDrain();

      $display("[TB] random soak");
      rand_mode = 1'b1;
      for (int n = 0; n < 10000; n++) begin
         for (int w = 0; w < 8; w++) m[w*32 +: 32] = $urandom();
         m[273:256] = 18'($urandom());
         applyStimulus(model(m));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      rand_mode = 1'b0;
      waitDrain();
      checkCounters("soak");

      $display("[TB] reset while full");
      man_ready = 1'b0;
      applyStimulus(model(vecs[1].meta));
      applyStimulus(model(vecs[3].meta));
      @(negedge clk);
      checkOutput("full_ready_low", MW'(s_ready), '0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rstfull_valid", MW'(m_valid), '0);
      checkOutput("rstfull_ready", MW'(s_ready), '0);
      sb_q.delete();
      ref_dat  = 0;
      ref_nack = 0;
      ref_miss = 0;
      checkCounters("rstfull");
      @(posedge clk);
      #1;
      rst       = 1'b0;
      man_ready = 1'b1;
      @(negedge clk);
      checkOutput("rstfull_ready_back", MW'(s_ready), MW'(1));
      @(posedge clk);
      #1;
      applyStimulus(model(vecs[6].meta));
      waitDrain();
      checkCounters("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
